wb_stage: RTL

- Writeback stage of the 8-bit pipeline. It sits directly downstream of the EX/WB latch and consumes its EX_WB_* outputs.
- Owns the architectural state: 8x8-bit register file, 16x8-bit data memory and the committed flag register.
- Commits results, performs loads and stores, raises PC redirects for jumps, and stalls upstream during loads.
- Provides two combinational register read ports to the decode stage.

---
 rtl/wb_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage of the 8-bit pipeline.
// Owns the register file, data memory and committed flags; commits results,
// performs loads/stores, raises PC redirects and stalls upstream during loads.
// Optional macro WB_BYPASS_EN: register read ports forward same-cycle writes.
module wb_stage #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   EX_WB_opcode,
    input  logic                         EX_WB_am,
    input  logic [$clog2(NUM_REGS)-1:0]  EX_WB_rd,
    input  logic [$clog2(MEM_DEPTH)-1:0] EX_WB_mem_addr,
    input  logic [5:0]                   EX_WB_instr_mem_addr,
    input  logic [2*DATA_W-1:0]          EX_WB_result,
    input  logic                         EX_WB_zero_flag,
    input  logic                         EX_WB_carry_flag,
    input  logic                         EX_WB_ac_flag,
    input  logic                         EX_WB_parity_flag,
    input  logic [$clog2(NUM_REGS)-1:0]  rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0]  rs2_addr,
    output logic [DATA_W-1:0]            rs1_data,
    output logic [DATA_W-1:0]            rs2_data,
    output logic [3:0]                   flags_out,
    output logic                         pc_load,
    output logic [5:0]                   pc_target,
    output logic                         stall,
    output logic                         halted
);

    localparam int unsigned RegAw = $clog2(NUM_REGS);
    localparam int unsigned MemAw = $clog2(MEM_DEPTH);

    localparam logic [4:0] OpMul   = 5'h10;
    localparam logic [4:0] OpLoad  = 5'h11;
    localparam logic [4:0] OpStore = 5'h12;
    localparam logic [4:0] OpJmp   = 5'h13;
    localparam logic [4:0] OpJz    = 5'h14;
    localparam logic [4:0] OpJc    = 5'h15;
    localparam logic [4:0] OpHalt  = 5'h1F;

    typedef enum logic [1:0] {StRun, StLoadWait, StHalt} state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  reg_file [NUM_REGS];
    logic [DATA_W-1:0]  mem      [MEM_DEPTH];
    logic [3:0]         flags_q;
    logic [DATA_W-1:0]  load_data_q;
    logic [RegAw-1:0]   load_rd_q;

    // Two register write ports: port a for every single write, port b for the MUL high half
    logic               wa_en, wb_en;
    logic [RegAw-1:0]   wa_addr, wb_addr;
    logic [DATA_W-1:0]  wa_data, wb_data;
    logic               mem_we, flags_we, load_start, jump_taken, go_halt;
    logic               is_alu;

    assign is_alu = (EX_WB_opcode >= 5'h01) && (EX_WB_opcode <= 5'h0F);

    // Decode the committed instruction into write enables and control strobes
    always_comb begin
        wa_en      = 1'b0;
        wa_addr    = EX_WB_rd;
        wa_data    = EX_WB_result[DATA_W-1:0];
        wb_en      = 1'b0;
        wb_addr    = {EX_WB_rd[RegAw-1:1], 1'b1};
        wb_data    = EX_WB_result[2*DATA_W-1:DATA_W];
        mem_we     = 1'b0;
        flags_we   = 1'b0;
        load_start = 1'b0;
        jump_taken = 1'b0;
        go_halt    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (is_alu) begin
                    wa_en    = 1'b1;
                    flags_we = 1'b1;
                end else begin
                    case (EX_WB_opcode)
                        OpMul: begin
                            wa_en    = 1'b1;
                            wa_addr  = {EX_WB_rd[RegAw-1:1], 1'b0};
                            wb_en    = 1'b1;
                            flags_we = 1'b1;
                        end
                        OpLoad: begin
                            if (EX_WB_am) wa_en = 1'b1;
                            else          load_start = 1'b1;
                        end
                        OpStore: mem_we     = 1'b1;
                        OpJmp:   jump_taken = 1'b1;
                        OpJz:    jump_taken = flags_q[3];
                        OpJc:    jump_taken = flags_q[2];
                        OpHalt:  go_halt    = 1'b1;
                        default: ;
                    endcase
                end
            end
            StLoadWait: begin
                // Inputs this cycle are the frozen LOAD; only the latched data matters
                wa_en   = 1'b1;
                wa_addr = load_rd_q;
                wa_data = load_data_q;
            end
            StHalt: ;
            default: ;
        endcase
    end

    // Stall during memory-load decode and while halted; held low during reset
    assign stall     = (load_start & ~rst) | (state_q == StHalt);
    assign halted    = (state_q == StHalt);
    assign flags_out = flags_q;

    // Architectural state: register file, data memory, flags and load latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
            flags_q     <= '0;
            load_data_q <= '0;
            load_rd_q   <= '0;
        end else begin
            if (wa_en) reg_file[wa_addr] <= wa_data;
            if (wb_en) reg_file[wb_addr] <= wb_data;
            if (mem_we) mem[EX_WB_mem_addr] <= EX_WB_result[DATA_W-1:0];
            if (flags_we) begin
                flags_q <= {EX_WB_zero_flag, EX_WB_carry_flag, EX_WB_ac_flag, EX_WB_parity_flag};
            end
            if (load_start) begin
                load_data_q <= mem[EX_WB_mem_addr[MemAw-1:0]];
                load_rd_q   <= EX_WB_rd;
            end
        end
    end

    // Control FSM with registered PC redirect strobe and target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            pc_load   <= 1'b0;
            pc_target <= '0;
        end else begin
            pc_load <= jump_taken;
            if (jump_taken) pc_target <= EX_WB_instr_mem_addr;
            unique case (state_q)
                StRun: begin
                    if (go_halt)         state_q <= StHalt;
                    else if (load_start) state_q <= StLoadWait;
                end
                StLoadWait: state_q <= StRun;
                StHalt:     state_q <= StHalt;
                default:    state_q <= StRun;
            endcase
        end
    end

    // Combinational read ports for decode
    always_comb begin
        rs1_data = reg_file[rs1_addr];
        rs2_data = reg_file[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wa_en && (wa_addr == rs1_addr)) rs1_data = wa_data;
        if (wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
        if (wa_en && (wa_addr == rs2_addr)) rs2_data = wa_data;
        if (wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
`else
`endif
    end

endmodule
